// File: rtl/johnson_slot_arbiter.sv
// Purpose : round-robin time-slot arbiter over 2*N requesters, slot pointer is an N-bit Johnson ring.
// Latency : request-to-grant 1 cycle when the ring points at the slot, else 1 + slot distance (max 2*N).
// Backpr. : a held grant blocks all others until done_i or the HOLD_MAX timeout releases it.
//
// Ports:
//   clk_i, reset_i      single clock, synchronous active-high reset
//   req_i[2N]           level-sensitive request per slot
//   done_i              grantee releases the resource (sampled while busy)
//   grant_o[2N]         registered one-hot grant; grant_idx_o is its index
//   busy_o              a grant is held
//   ring_q_o, ring_en_o Johnson ring state and per-bit toggle enables (clock-gating hooks)
//   timeout_o           one-cycle pulse when a grant is revoked by HOLD_MAX
//   illegal_o           one-cycle pulse when a non-Johnson ring code was flushed to 0
module johnson_slot_arbiter #(
    parameter int N        = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [2*N-1:0]         req_i,
    input  logic                   done_i,
    output logic [2*N-1:0]         grant_o,
    output logic [$clog2(2*N)-1:0] grant_idx_o,
    output logic                   busy_o,
    output logic [N-1:0]           ring_q_o,
    output logic [N-1:0]           ring_en_o,
    output logic                   timeout_o,
    output logic                   illegal_o
);
    localparam int S  = 2 * N;
    localparam int SW = $clog2(S);
    localparam int CW = $clog2(N + 1);
    localparam int HW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_MAX > 0) ? HOLD_MAX - 1 : 0);
    localparam bit HOLD_EN = (HOLD_MAX != 0);

    typedef enum logic {SCAN, BUSY} state_t;

    state_t          state_q;
    logic [N-1:0]    ring_q;
    logic [N-1:0]    ring_d;
    logic [N-1:0]    ring_nxt;
    logic [N-1:0]    ring_inv;
    logic [S-1:0]    grant_q;
    logic [SW-1:0]   idx_q;
    logic [HW-1:0]   hold_q;
    logic            timeout_q;
    logic            illegal_q;

    logic [CW-1:0]   ones;
    logic [SW-1:0]   slot;
    logic            legal;
    logic            req_hit;
    logic            any_req;
    logic            rel_done;
    logic            rel_to;
    logic            advance;

    assign ring_nxt = {ring_q[N-2:0], ~ring_q[N-1]};
    assign ring_inv = ~ring_q;

    // A run of 1s anchored at bit 0 has the form 2^k-1, so x & (x+1) == 0.
    // A run anchored at bit N-1 is the complement of such a value.
    assign legal = ((ring_q & (ring_q + N'(1))) == '0) ||
                   ((ring_inv & (ring_inv + N'(1))) == '0);

    always_comb begin
        ones = '0;
        for (int i = 0; i < N; i++) begin
            ones = ones + CW'(ring_q[i]);
        end
    end

    // Rising half of the lap counts 1s up from slot 0; falling half counts down from slot 2N.
    assign slot    = ring_q[N-1] ? SW'(S - int'(ones)) : SW'(ones);
    assign req_hit = req_i[slot];
    assign any_req = |req_i;

    // done has priority over the timeout in the same cycle.
    assign rel_done = (state_q == BUSY) && done_i;
    assign rel_to   = (state_q == BUSY) && !done_i && HOLD_EN && (hold_q == HOLD_LAST);

    // Step on release (round-robin: next scan starts past the old grantee) or while
    // scanning past an idle slot with some request pending. Never from an illegal code.
    assign advance = !reset_i && legal &&
                     ((state_q == BUSY) ? (rel_done || rel_to) : (any_req && !req_hit));

    assign ring_d    = !legal ? '0 : (advance ? ring_nxt : ring_q);
    assign ring_en_o = advance ? (ring_nxt ^ ring_q) : '0;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= SCAN;
            ring_q    <= '0;
            grant_q   <= '0;
            idx_q     <= '0;
            hold_q    <= '0;
            timeout_q <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            ring_q    <= ring_d;
            timeout_q <= 1'b0;
            illegal_q <= !legal;
            case (state_q)
                SCAN: begin
                    if (legal && req_hit) begin
                        grant_q <= S'(1) << slot;
                        idx_q   <= slot;
                        hold_q  <= '0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel_done || rel_to) begin
                        grant_q   <= '0;
                        timeout_q <= rel_to;
                        state_q   <= SCAN;
                    end else begin
                        hold_q <= hold_q + HW'(1);
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign grant_o     = grant_q;
    assign grant_idx_o = idx_q;
    assign busy_o      = (state_q == BUSY);
    assign ring_q_o    = ring_q;
    assign timeout_o   = timeout_q;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_johnson_slot_arbiter.sv
module tb_johnson_slot_arbiter;
    localparam int N        = 4;
    localparam int S        = 2 * N;
    localparam int HOLD_MAX = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          done = 1'b0;
    logic [S-1:0]  req = '0;
    logic [S-1:0]  grant;
    logic [2:0]    grant_idx;
    logic          busy;
    logic [N-1:0]  ring_q;
    logic [N-1:0]  ring_en;
    logic          timeout;
    logic          illegal;

    always #5 clk = ~clk;

    johnson_slot_arbiter #(.N(N), .HOLD_MAX(HOLD_MAX)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .req_i       (req),
        .done_i      (done),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .busy_o      (busy),
        .ring_q_o    (ring_q),
        .ring_en_o   (ring_en),
        .timeout_o   (timeout),
        .illegal_o   (illegal)
    );

    typedef struct packed {
        logic [S-1:0] grant;
        logic [2:0]   idx;
        logic         busy;
        logic [N-1:0] ring;
        logic         timeout;
        logic         illegal;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: the pointer is a plain slot number, mapped to its Johnson code.
    int           m_slot  = 0;
    logic         m_busy  = 1'b0;
    int           m_idx   = 0;
    int           m_hold  = 0;
    logic [S-1:0] m_grant = '0;
    logic         inject  = 1'b0;

    // Observed-side bookkeeping for directed checks
    int   dut_log[$];
    logic prev_busy  = 1'b0;
    int   since_gnt  = 0;
    int   n_timeouts = 0;

    function automatic logic [N-1:0] code_of(input int s);
        if (s <= N) return N'((1 << s) - 1);
        return ~N'((1 << (s - N)) - 1);
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input logic [S-1:0] r, input logic d, input logic rst);
        exp_t         e;
        exp_t         o;
        logic [N-1:0] en_exp;
        logic         adv;
        @(negedge clk);
        req   = r;
        done  = d;
        reset = rst;
        if (inject) force dut.ring_q = 4'b0101;
        #1;
        adv       = 1'b0;
        e.timeout = 1'b0;
        e.illegal = 1'b0;
        if (rst) begin
            m_slot = 0; m_busy = 1'b0; m_idx = 0; m_hold = 0; m_grant = '0;
        end else if (inject) begin
            m_slot    = 0;
            e.illegal = 1'b1;
        end else if (!m_busy) begin
            if (r[m_slot]) begin
                m_busy = 1'b1; m_idx = m_slot; m_hold = 0; m_grant = S'(1) << m_slot;
            end else if (r != '0) begin
                adv = 1'b1;
            end
        end else begin
            if (d || (m_hold == HOLD_MAX - 1)) begin
                adv = 1'b1; e.timeout = !d; m_busy = 1'b0; m_grant = '0;
            end else begin
                m_hold++;
            end
        end
        en_exp = adv ? (code_of((m_slot + 1) % S) ^ code_of(m_slot)) : '0;
        check_val("ring_en", ring_en, en_exp);
        if (adv) check_val("ring_en_onehot", $countones(ring_en), 1);
        if (adv) m_slot = (m_slot + 1) % S;
        e.grant = m_grant;
        e.idx   = 3'(m_idx);
        e.busy  = m_busy;
        e.ring  = code_of(m_slot);
        sb_q.push_back(e);
        if (inject) begin
            #2;
            release dut.ring_q;
        end
        @(posedge clk);
        #1;
        check_val("sb_depth", sb_q.size(), 1);
        o = sb_q.pop_front();
        check_val("grant",     grant,     o.grant);
        check_val("grant_idx", grant_idx, o.idx);
        check_val("busy",      busy,      o.busy);
        check_val("ring_q",    ring_q,    o.ring);
        check_val("timeout",   timeout,   o.timeout);
        check_val("illegal",   illegal,   o.illegal);
        since_gnt++;
        if (busy && !prev_busy) begin
            dut_log.push_back(int'(grant_idx));
            since_gnt = 0;
        end
        if (timeout) begin
            n_timeouts++;
            check_val("timeout_latency", since_gnt, HOLD_MAX);
        end
        prev_busy = busy;
    endtask

    // done is raised in the busy cycle whose hold count equals done_at (-1: never)
    task automatic run(input logic [S-1:0] r, input int done_at, input int n);
        for (int i = 0; i < n; i++) begin
            tick(r, (done_at >= 0) && m_busy && (m_hold == done_at), 1'b0);
        end
    endtask

    initial begin
        int base;
        int to_before;

        // Reset state and single request at the pointer
        tick('0, 1'b0, 1'b1);
        tick('0, 1'b0, 1'b1);
        run(8'h01, -1, 1);
        run(8'h00, 2, 5);

        // Walk to slot 5
        tick('0, 1'b0, 1'b1);
        run(8'h20, -1, 6);
        check_val("walk_grant_idx", dut_log[dut_log.size() - 1], 5);
        run(8'h00, 0, 3);

        // Two requesters alternate
        tick('0, 1'b0, 1'b1);
        base = dut_log.size();
        run(8'h81, 1, 16);
        check_val("alt_first",  dut_log[base],     0);
        check_val("alt_second", dut_log[base + 1], 7);
        check_val("alt_third",  dut_log[base + 2], 0);
        run(8'h00, 0, 3);

        // Timeout on slot 3, then release in the last allowed cycle
        tick('0, 1'b0, 1'b1);
        to_before = n_timeouts;
        run(8'h08, -1, 4);
        run(8'h00, -1, 18);
        check_val("timeout_seen", n_timeouts - to_before, 1);
        to_before = n_timeouts;
        run(8'h08, 15, 30);
        run(8'h00, 15, 18);
        check_val("no_timeout_on_last_done", n_timeouts - to_before, 0);

        // Illegal ring code flush, then idle
        run(8'h00, -1, 2);
        inject = 1'b1;
        tick('0, 1'b0, 1'b0);
        inject = 1'b0;
        run(8'h00, -1, 20);

        // Reset in the middle of a grant, then regrant
        tick('0, 1'b0, 1'b1);
        run(8'h04, -1, 3);
        check_val("pre_reset_busy", busy, 1);
        tick(8'h04, 1'b0, 1'b1);
        base = dut_log.size();
        run(8'h04, -1, 3);
        check_val("regrant_idx", dut_log[base], 2);
        run(8'h00, 0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
